// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker and the system-ID slave
// generator.
//   state_t             : checker FSM states, 3-bit encoding
//   ADDR_ID / ADDR_TS   : word addresses of the ID and timestamp registers
//   DEFAULT_EXPECTED_TS : build timestamp the slave generator embeds by default
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_ID = 3'd1,
    LAT_ID = 3'd2,
    REQ_TS = 3'd3,
    LAT_TS = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1647291630;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID
// slave.
//   address     : word address (0 = ID, 1 = timestamp)
//   read        : read strobe
//   waitrequest : slave stall
//   readdata    : 32-bit read data
interface sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/sysid_checker.sv
// System-ID checker: on request reads the ID word then the build timestamp
// from the sysid slave, compares both with the expected values and latches
// the captured words and pass/fail flags for software or boot logic to poll.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset (sync release)
//   start          : one-cycle check request, ignored while busy
//   avm            : Avalon-MM master side of the sysid link
//   busy / done    : check in progress / one-cycle end-of-check pulse
//   id_value, ts_value : last captured words
//   id_ok, ts_ok, timeout_err : result flags of the last check
// Optional build macro SYSID_CHECKER_AUTOSTART_EN: runs one check by itself
// in the first cycle after reset is released.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  sysid_checker_if.master     avm,
  output logic                busy,
  output logic                done,
  output logic [31:0]         id_value,
  output logic [31:0]         ts_value,
  output logic                id_ok,
  output logic                ts_ok,
  output logic                timeout_err
);

  // One counter serves both the stall timeout and the read-latency wait.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > READ_LATENCY) ? TIMEOUT_CYCLES : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       rst_sync_reg;
  logic             rst_n;
  logic             start_eff;
  logic             timeout_hit;
  logic             cap_id, cap_ts;
  logic             read_next, addr_next;
  logic             read_reg, addr_reg;
  logic [31:0]      id_value_reg, ts_value_reg, ts_cmp;
  logic             id_ok_reg, ts_ok_reg, timeout_err_reg;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

`ifdef SYSID_CHECKER_AUTOSTART_EN
  // Set by reset, so a reset in the middle of a check re-arms it.
  logic auto_arm_reg;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) auto_arm_reg <= 1'b1;
    else        auto_arm_reg <= 1'b0;
  end
  assign start_eff = start | auto_arm_reg;
`else
  assign start_eff = start;
`endif

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE:   if (start_eff) state_next = REQ_ID;
      REQ_ID: begin
        if (!avm.waitrequest) begin
          state_next = (READ_LATENCY == 0) ? REQ_TS : LAT_ID;
        end else if (cnt_reg == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = FINISH;
        end
      end
      LAT_ID: if (cnt_reg == LAT_LAST) state_next = REQ_TS;
      REQ_TS: begin
        if (!avm.waitrequest) begin
          state_next = (READ_LATENCY == 0) ? FINISH : LAT_TS;
        end else if (cnt_reg == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = FINISH;
        end
      end
      LAT_TS: if (cnt_reg == LAT_LAST) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    busy   = (state_reg != IDLE);
    done   = (state_reg == FINISH);
    cap_id = ((state_reg == REQ_ID) && !avm.waitrequest && (READ_LATENCY == 0)) ||
             ((state_reg == LAT_ID) && (cnt_reg == LAT_LAST));
    cap_ts = ((state_reg == REQ_TS) && !avm.waitrequest && (READ_LATENCY == 0)) ||
             ((state_reg == LAT_TS) && (cnt_reg == LAT_LAST));
    // The bus strobes are registered from the state being entered, so they
    // are valid from the first cycle of REQ_* and held through stalls.
    read_next = (state_next == REQ_ID) || (state_next == REQ_TS);
    addr_next = ((state_next == REQ_TS) || (state_next == LAT_TS)) ? ADDR_TS : ADDR_ID;
    // The timestamp is compared on the same edge that captures it.
    ts_cmp    = cap_ts ? avm.readdata : ts_value_reg;
  end

  // Counter restarts on every state entry; counts stalls in REQ_* and
  // elapsed cycles in LAT_*.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if ((read_reg && avm.waitrequest) ||
                 (state_reg == LAT_ID) || (state_reg == LAT_TS)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      read_reg        <= 1'b0;
      addr_reg        <= ADDR_ID;
      id_value_reg    <= '0;
      ts_value_reg    <= '0;
      id_ok_reg       <= 1'b0;
      ts_ok_reg       <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      read_reg <= read_next;
      addr_reg <= addr_next;
      if (cap_id) id_value_reg <= avm.readdata;
      if (cap_ts) ts_value_reg <= avm.readdata;
      if ((state_reg == IDLE) && start_eff) begin
        id_ok_reg       <= 1'b0;
        ts_ok_reg       <= 1'b0;
        timeout_err_reg <= 1'b0;
      end else if ((state_next == FINISH) && (state_reg != FINISH)) begin
        if (timeout_hit) begin
          timeout_err_reg <= 1'b1;
          id_ok_reg       <= 1'b0;
          ts_ok_reg       <= 1'b0;
        end else begin
          id_ok_reg <= (id_value_reg == EXPECTED_ID);
          ts_ok_reg <= (ts_cmp == EXPECTED_TS);
        end
      end
    end
  end

  assign avm.read    = read_reg;
  assign avm.address = addr_reg;
  assign id_value    = id_value_reg;
  assign ts_value    = ts_value_reg;
  assign id_ok       = id_ok_reg;
  assign ts_ok       = ts_ok_reg;
  assign timeout_err = timeout_err_reg;

endmodule
